rx_mac: RTL and testbench
=========================

RX_MAC -- requirements
Module: rx_mac

Interface
REQ-001 Parameter MIN_LEN, default 64, SHALL be the minimum legal frame length in bytes (destination address through FCS).
REQ-002 Parameter MAX_LEN, default 1518, SHALL be the maximum legal frame length in bytes (destination address through FCS).
REQ-003 RX_CLK  input  1  SHALL be the single clock: GMII receive clock, 125 MHz; all logic on rising edge.
REQ-004 SYS_RST_N  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 GMII_RXD  input  8  SHALL carry the GMII receive byte.
REQ-006 GMII_RX_DV  input  1  SHALL be the GMII receive data valid.
REQ-007 GMII_RX_ER  input  1  SHALL be the GMII receive error.
REQ-008 RX_DATA  output  8  SHALL carry the frame byte; FCS is never forwarded.
REQ-009 RX_VALID  output  1  SHALL qualify RX_DATA; it has no backpressure.
REQ-010 RX_SOF  output  1  SHALL be high with the first forwarded byte of a frame.
REQ-011 RX_DONE  output  1  SHALL be a one-cycle end-of-frame status strobe.
REQ-012 RX_LEN  output  11  SHALL give the frame byte count including FCS, saturating at 2047; valid with RX_DONE.
REQ-013 RX_STATUS  output  4  SHALL give the error flags, valid with RX_DONE: [0] CRC bad, [1] runt, [2] oversize, [3] RX_ER seen.
REQ-014 RX_BUSY  output  1  SHALL be high while in PREAMBLE or DATA.

Function
REQ-015 The FSM SHALL have the states WAIT_IDLE, IDLE, PREAMBLE and DATA.
REQ-016 WAIT_IDLE SHALL go to IDLE on the first cycle with DV sampled low.
REQ-017 IDLE SHALL go to PREAMBLE on DV=1 with RXD=0x55; on any other DV=1 byte (including 0xD5) or RX_ER=1 it SHALL go to WAIT_IDLE.
REQ-018 PREAMBLE SHALL accept 1..7 bytes of 0x55 and go to DATA on 0xD5.
REQ-019 PREAMBLE SHALL go to WAIT_IDLE on an 8th 0x55, on any other byte, or on RX_ER=1.
REQ-020 PREAMBLE SHALL go to IDLE on DV=0 without asserting RX_DONE.
REQ-021 DATA SHALL process every DV=1 byte through CRC, length and delay logic, and SHALL go to IDLE on DV=0.
REQ-022 The CRC SHALL be CRC-32, reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at SFD, processed LSB-first over all bytes after SFD including FCS.
REQ-023 A frame SHALL be CRC-good iff the final register equals 0xDEBB20E3.
REQ-024 The delay line SHALL be 4 bytes deep: a byte sampled at edge N SHALL appear on RX_DATA/RX_VALID after edge N+4, and only if a further DV=1 byte is sampled at edge N+4.
REQ-025 As a result of REQ-024, the last 4 bytes (the FCS) SHALL never be forwarded, and frames of 4 bytes or fewer after SFD SHALL forward nothing.
REQ-026 RX_SOF SHALL coincide with the first RX_VALID of each frame.
REQ-027 RX_DONE SHALL pulse for one cycle on the edge after DV is first sampled low in DATA, with RX_LEN and RX_STATUS stable during that cycle.
REQ-028 RX_STATUS[1] SHALL be set if LEN < MIN_LEN.
REQ-029 RX_STATUS[2] SHALL be set if LEN > MAX_LEN, and bytes beyond MAX_LEN SHALL NOT be forwarded.
REQ-030 RX_STATUS[3] SHALL be set if RX_ER=1 on any DATA byte.
REQ-031 The CRC check SHALL still be evaluated when other error flags are set.
REQ-032 A frame SHALL be good iff RX_STATUS=0.
REQ-033 A new preamble sampled on the cycle RX_DONE is high SHALL be accepted, so a 1-cycle inter-frame gap is legal.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 On SYS_RST_N=0 all outputs SHALL go to 0 immediately, the FSM SHALL go to WAIT_IDLE, and the CRC, counters and delay line SHALL clear.
REQ-036 A frame in progress at reset, or with DV still high at reset release, SHALL be discarded with no RX_VALID and no RX_DONE.

Structure
REQ-037 Package eth_pkg SHALL hold: PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_POLY 0xEDB88320, CRC_RESIDUE 0xDEBB20E3, the FSM state enum and the RX_STATUS bit indices.
REQ-038 Sub-module crc32_d8 SHALL provide the combinational 8-bit-per-cycle CRC next-state function; it SHALL be shared with TX_MAC.

Verification
REQ-039 Scenario: 7x0x55, 0xD5, then 60 bytes and a correct FCS -> 60 RX_VALID bytes identical to input, RX_SOF on byte 0, RX_DONE with LEN=64 and STATUS=0.
REQ-040 Scenario: same frame with byte 10 flipped -> 60 bytes forwarded, RX_DONE with STATUS=4'b0001.
REQ-041 Scenario: 40-byte valid-CRC frame -> RX_DONE with LEN=40 and STATUS=4'b0010; a 1600-byte frame -> 1514 bytes forwarded, LEN=1600, STATUS[2]=1.
REQ-042 Scenario: RX_ER pulsed on byte 20 of a 64-byte frame -> STATUS[3]=1; RX_ER pulsed during preamble -> no output until DV low, and the next frame is received good.
REQ-043 Scenario: SYS_RST_N pulsed low at byte 30 with DV held high -> outputs 0 at once, no RX_DONE for that frame, and the following frame is good.
REQ-044 Scenario: two 64-byte frames with a 1-cycle DV gap -> two RX_DONE strobes, both STATUS=0.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, RX FSM state type and RX_STATUS bit positions.
package eth_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  localparam int ST_CRC  = 0;
  localparam int ST_RUNT = 1;
  localparam int ST_OVER = 2;
  localparam int ST_RXER = 3;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, PREAMBLE, DATA} rx_state_e;
endpackage

// File: rtl/rx_mac_if.sv
// GMII receive inputs and the forwarded frame stream with end-of-frame status.
interface rx_mac_if;
  logic [7:0]  GMII_RXD;
  logic        GMII_RX_DV;
  logic        GMII_RX_ER;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_SOF;
  logic        RX_DONE;
  logic [10:0] RX_LEN;
  logic [3:0]  RX_STATUS;
  logic        RX_BUSY;

  // master: the MAC, consuming GMII and producing the frame stream
  modport master (input GMII_RXD, GMII_RX_DV, GMII_RX_ER,
                  output RX_DATA, RX_VALID, RX_SOF, RX_DONE, RX_LEN, RX_STATUS, RX_BUSY);
  modport slave  (output GMII_RXD, GMII_RX_DV, GMII_RX_ER,
                  input RX_DATA, RX_VALID, RX_SOF, RX_DONE, RX_LEN, RX_STATUS, RX_BUSY);
endinterface

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected) next state for one byte, LSB first.
module crc32_d8 import eth_pkg::*; (
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);
  always_comb begin
    o_crc = i_crc;
    for (int i = 0; i < 8; i++)
      o_crc = (o_crc[0] ^ i_data[i]) ? ((o_crc >> 1) ^ CRC_POLY) : (o_crc >> 1);
  end
endmodule

// File: rtl/rx_mac.sv
// GMII receive MAC: preamble/SFD detection, CRC check, length checks and a
// 4-byte delay line that strips the FCS from the forwarded stream.
module rx_mac import eth_pkg::*; #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic     RX_CLK,
  input  logic     SYS_RST_N,
  rx_mac_if.master bus
);
  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [10:0] LEN_SAT = '1;

  rx_state_e       r_state;
  logic [2:0]      r_pre_cnt;
  logic [31:0]     r_crc;
  logic [10:0]     r_cnt;
  logic            r_er;
  logic [3:0][7:0] r_dly;
  logic [31:0]     w_crc_nxt;
  logic            w_fwd;
  logic [3:0]      w_status;

  crc32_d8 u_crc (.i_crc(r_crc), .i_data(bus.GMII_RXD), .o_crc(w_crc_nxt));

  // r_cnt is the index of the byte being sampled; the byte 4 behind it leaves
  // only when another byte arrives, so the FCS is never forwarded.
  assign w_fwd = (r_cnt >= 11'd4) && (r_cnt < MAX_L);

  always_comb begin
    w_status           = '0;
    w_status[ST_CRC]   = (r_crc != CRC_RESIDUE);
    w_status[ST_RUNT]  = (r_cnt < MIN_L);
    w_status[ST_OVER]  = (r_cnt > MAX_L);
    w_status[ST_RXER]  = r_er;
  end

  always_ff @(posedge RX_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      r_state       <= WAIT_IDLE;
      r_pre_cnt     <= '0;
      r_crc         <= '0;
      r_cnt         <= '0;
      r_er          <= 1'b0;
      r_dly         <= '0;
      bus.RX_DATA   <= '0;
      bus.RX_VALID  <= 1'b0;
      bus.RX_SOF    <= 1'b0;
      bus.RX_DONE   <= 1'b0;
      bus.RX_LEN    <= '0;
      bus.RX_STATUS <= '0;
      bus.RX_BUSY   <= 1'b0;
    end else begin
      bus.RX_VALID <= 1'b0;
      bus.RX_SOF   <= 1'b0;
      bus.RX_DONE  <= 1'b0;
      case (r_state)
        WAIT_IDLE: if (!bus.GMII_RX_DV) r_state <= IDLE;
        IDLE: begin
          if (bus.GMII_RX_ER) r_state <= WAIT_IDLE;
          else if (bus.GMII_RX_DV) begin
            if (bus.GMII_RXD == PREAMBLE_BYTE) begin
              r_state     <= PREAMBLE;
              r_pre_cnt   <= 3'd1;
              bus.RX_BUSY <= 1'b1;
            end else r_state <= WAIT_IDLE;
          end
        end
        PREAMBLE: begin
          if (!bus.GMII_RX_DV) begin
            r_state     <= IDLE;
            bus.RX_BUSY <= 1'b0;
          end else if (bus.GMII_RX_ER) begin
            r_state     <= WAIT_IDLE;
            bus.RX_BUSY <= 1'b0;
          end else if (bus.GMII_RXD == SFD_BYTE) begin
            r_state <= DATA;
            r_crc   <= CRC_INIT;
            r_cnt   <= '0;
            r_er    <= 1'b0;
          end else if (bus.GMII_RXD == PREAMBLE_BYTE && r_pre_cnt < 3'd7) begin
            r_pre_cnt <= r_pre_cnt + 3'd1;
          end else begin
            r_state     <= WAIT_IDLE;
            bus.RX_BUSY <= 1'b0;
          end
        end
        DATA: begin
          if (!bus.GMII_RX_DV) begin
            r_state       <= IDLE;
            bus.RX_BUSY   <= 1'b0;
            bus.RX_DONE   <= 1'b1;
            bus.RX_LEN    <= r_cnt;
            bus.RX_STATUS <= w_status;
          end else begin
            r_crc <= w_crc_nxt;
            if (r_cnt != LEN_SAT) r_cnt <= r_cnt + 11'd1;
            if (bus.GMII_RX_ER) r_er <= 1'b1;
            r_dly <= {r_dly[2:0], bus.GMII_RXD};
            if (w_fwd) begin
              bus.RX_VALID <= 1'b1;
              bus.RX_DATA  <= r_dly[3];
              bus.RX_SOF   <= (r_cnt == 11'd4);
            end
          end
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_mac.sv
// Randomised and directed frames against a queue-based frame model.
module tb_rx_mac;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  rx_mac_if bus();
  rx_mac #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (.RX_CLK(clk), .SYS_RST_N(rst_n), .bus(bus));

  int n_chk = 0, n_pass = 0;
  int n_valid = 0, n_done = 0;
  logic [10:0] last_len;
  logic [3:0]  last_st;
  logic [7:0]  q_data[$];
  logic        q_sof[$];
  logic [14:0] q_done[$];
  logic [7:0]  fr[$];
  logic [7:0]  e_d;
  logic        e_s;
  logic [14:0] e_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Standard CRC-32 (with final inversion) of the first cnt bytes.
  function automatic logic [31:0] fcs_of(input logic [7:0] b[$], input int cnt);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic make_frame(input int n);
    logic [31:0] f;
    fr.delete();
    for (int i = 0; i < n - 4; i++) fr.push_back(8'($urandom_range(0, 255)));
    f = fcs_of(fr, n - 4);
    for (int i = 0; i < 4; i++) fr.push_back(f[8*i +: 8]);
  endtask

  // Frame-level expectation: everything but the last 4 bytes, capped at MAX_LEN-4.
  task automatic expect_frame(input bit er);
    int n, nf;
    logic [31:0] f;
    logic [3:0] st;
    logic [10:0] len;
    n  = fr.size();
    nf = (n > 4) ? n - 4 : 0;
    if (nf > MAX_LEN - 4) nf = MAX_LEN - 4;
    for (int i = 0; i < nf; i++) begin q_data.push_back(fr[i]); q_sof.push_back(i == 0); end
    f = fcs_of(fr, n - 4);
    st[0] = ({fr[n-1], fr[n-2], fr[n-3], fr[n-4]} != f);
    st[1] = (n < MIN_LEN);
    st[2] = (n > MAX_LEN);
    st[3] = er;
    len = (n > 2047) ? 11'd2047 : 11'(n);
    q_done.push_back({len, st});
  endtask

  task automatic send(input int pre, input int data_er, input int pre_er, input int gap, input int rst_at);
    for (int i = 0; i < pre; i++) begin
      @(negedge clk);
      bus.GMII_RX_DV = 1'b1; bus.GMII_RXD = 8'h55; bus.GMII_RX_ER = (i == pre_er);
    end
    @(negedge clk);
    bus.GMII_RXD = 8'hD5; bus.GMII_RX_ER = 1'b0;
    if (pre <= 7 && pre_er < 0) chk("busy_in_preamble", 32'(bus.RX_BUSY), 32'd1);
    for (int i = 0; i < fr.size(); i++) begin
      @(negedge clk);
      bus.GMII_RXD = fr[i]; bus.GMII_RX_ER = (i == data_er);
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid",  32'(bus.RX_VALID),  32'd0);
        chk("rst_sof",    32'(bus.RX_SOF),    32'd0);
        chk("rst_done",   32'(bus.RX_DONE),   32'd0);
        chk("rst_data",   32'(bus.RX_DATA),   32'd0);
        chk("rst_len",    32'(bus.RX_LEN),    32'd0);
        chk("rst_status", 32'(bus.RX_STATUS), 32'd0);
        chk("rst_busy",   32'(bus.RX_BUSY),   32'd0);
        q_data.delete(); q_sof.delete(); q_done.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
      end
    end
    for (int j = 0; j < gap; j++) begin
      @(negedge clk);
      bus.GMII_RX_DV = 1'b0; bus.GMII_RX_ER = 1'b0; bus.GMII_RXD = 8'h00;
      if (j == 1) chk("busy_after_frame", 32'(bus.RX_BUSY), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.RX_VALID) begin
        n_valid++;
        if (q_data.size() == 0) chk("unexpected_valid", 32'(bus.RX_VALID), 32'd0);
        else begin
          e_d = q_data.pop_front();
          e_s = q_sof.pop_front();
          chk("rx_data", 32'(bus.RX_DATA), 32'(e_d));
          chk("rx_sof",  32'(bus.RX_SOF),  32'(e_s));
        end
      end else if (bus.RX_SOF) chk("sof_without_valid", 32'(bus.RX_SOF), 32'd0);
      if (bus.RX_DONE) begin
        n_done++;
        last_len = bus.RX_LEN;
        last_st  = bus.RX_STATUS;
        if (q_done.size() == 0) chk("unexpected_done", 32'(bus.RX_DONE), 32'd0);
        else begin
          e_done = q_done.pop_front();
          chk("rx_len",    32'(bus.RX_LEN),    32'(e_done[14:4]));
          chk("rx_status", 32'(bus.RX_STATUS), 32'(e_done[3:0]));
        end
      end
    end
  end

  initial begin
    int v0, d0, n, idx, er, pre, gap;
    logic [7:0] ascii[$];
    bus.GMII_RXD = 8'h00; bus.GMII_RX_DV = 1'b0; bus.GMII_RX_ER = 1'b0;
    #1;
    chk("init_valid",  32'(bus.RX_VALID),  32'd0);
    chk("init_done",   32'(bus.RX_DONE),   32'd0);
    chk("init_len",    32'(bus.RX_LEN),    32'd0);
    chk("init_status", 32'(bus.RX_STATUS), 32'd0);
    chk("init_busy",   32'(bus.RX_BUSY),   32'd0);
    for (int i = 0; i < 9; i++) ascii.push_back(8'(8'h31 + i));
    chk("model_crc_check_value", fcs_of(ascii, 9), 32'hCBF43926);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // good minimum frame
    make_frame(64); expect_frame(1'b0); v0 = n_valid; d0 = n_done;
    send(7, -1, -1, 3, -1); #1;
    chk("s1_fwd", 32'(n_valid - v0), 32'd60); chk("s1_done", 32'(n_done - d0), 32'd1);
    chk("s1_len", 32'(last_len), 32'd64);     chk("s1_st", 32'(last_st), 32'd0);

    // corrupted byte 10
    make_frame(64); fr[10] = fr[10] ^ 8'hFF; expect_frame(1'b0); v0 = n_valid;
    send(7, -1, -1, 3, -1); #1;
    chk("s2_fwd", 32'(n_valid - v0), 32'd60); chk("s2_st", 32'(last_st), 32'd1);

    // runt
    make_frame(40); expect_frame(1'b0); v0 = n_valid;
    send(7, -1, -1, 3, -1); #1;
    chk("s3_fwd", 32'(n_valid - v0), 32'd36);
    chk("s3_len", 32'(last_len), 32'd40); chk("s3_st", 32'(last_st), 32'd2);

    // oversize
    make_frame(1600); expect_frame(1'b0); v0 = n_valid;
    send(7, -1, -1, 3, -1); #1;
    chk("s4_fwd", 32'(n_valid - v0), 32'd1514);
    chk("s4_len", 32'(last_len), 32'd1600); chk("s4_st", 32'(last_st), 32'd4);

    // RX_ER in data
    make_frame(64); expect_frame(1'b1);
    send(7, 20, -1, 3, -1); #1;
    chk("s5_st", 32'(last_st), 32'd8);

    // RX_ER in preamble drops the frame; next one is good
    make_frame(64); d0 = n_done; v0 = n_valid;
    send(7, -1, 3, 3, -1); #1;
    chk("s6_drop_done", 32'(n_done - d0), 32'd0); chk("s6_drop_fwd", 32'(n_valid - v0), 32'd0);
    make_frame(64); expect_frame(1'b0);
    send(5, -1, -1, 3, -1); #1;
    chk("s6_next_st", 32'(last_st), 32'd0);

    // reset in mid-frame with DV held high
    make_frame(64); expect_frame(1'b0); d0 = n_done; v0 = n_valid;
    send(7, -1, -1, 3, 30); #1;
    chk("s7_fwd_before", 32'(n_valid - v0), 32'd26); chk("s7_no_done", 32'(n_done - d0), 32'd0);
    make_frame(64); expect_frame(1'b0); d0 = n_done;
    send(7, -1, -1, 3, -1); #1;
    chk("s7_next_done", 32'(n_done - d0), 32'd1); chk("s7_next_st", 32'(last_st), 32'd0);

    // back-to-back with a single idle cycle
    d0 = n_done;
    make_frame(64); expect_frame(1'b0); send(7, -1, -1, 1, -1);
    make_frame(64); expect_frame(1'b0); send(1, -1, -1, 3, -1); #1;
    chk("s8_done", 32'(n_done - d0), 32'd2); chk("s8_st", 32'(last_st), 32'd0);

    // boundaries: 4-byte frame forwards nothing, 5-byte forwards one, 8x 0x55 rejected
    make_frame(4); expect_frame(1'b0); v0 = n_valid;
    send(3, -1, -1, 3, -1); #1;
    chk("b4_fwd", 32'(n_valid - v0), 32'd0); chk("b4_len", 32'(last_len), 32'd4);
    chk("b4_st", 32'(last_st), 32'd2);
    make_frame(5); expect_frame(1'b0); v0 = n_valid;
    send(2, -1, -1, 3, -1); #1;
    chk("b5_fwd", 32'(n_valid - v0), 32'd1);
    make_frame(64); d0 = n_done;
    send(8, -1, -1, 3, -1); #1;
    chk("pre8_done", 32'(n_done - d0), 32'd0);

    // random frames
    for (int r = 0; r < 16; r++) begin
      n = $urandom_range(4, 130);
      make_frame(n);
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, n - 1);
        fr[idx] = fr[idx] ^ 8'(8'h01 << $urandom_range(0, 7));
      end
      er  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      pre = $urandom_range(1, 7);
      gap = $urandom_range(1, 4);
      expect_frame(er >= 0);
      send(pre, er, -1, gap, -1);
    end

    repeat (10) @(negedge clk);
    chk("pending_bytes", 32'(q_data.size()), 32'd0);
    chk("pending_done",  32'(q_done.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
